// File: rtl/au_absval_serial_pkg.sv
// Shared definitions for the AU_ arithmetic blocks: prefix-network
// architecture selectors and small elaboration-time helpers.
package au_absval_serial_pkg;

  // Prefix-network architecture encodings understood by AU_prefix_and.
  localparam int AU_ARCH_SKLANSKY    = 0;
  localparam int AU_ARCH_KOGGE_STONE = 1;
  localparam int AU_ARCH_RIPPLE      = 2;

  // Bits needed to index n items; never less than one so that a
  // single-item counter still has a legal declaration.
  function automatic int au_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/au_absval_serial_prefix_and.sv
// AU_prefix_and: p_o[i] = &x_i[i:0]. Used as a chained incrementer:
// feeding {t, carry_in} gives the per-bit increment toggles in the low
// bits and the carry out in the top bit.
module AU_prefix_and
  import au_absval_serial_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int ARCH  = AU_ARCH_SKLANSKY
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] p_o
);

  localparam int LVLS = au_clog2_min1(WIDTH);

  if (ARCH == AU_ARCH_RIPPLE) begin : g_ripple

    // Linear AND chain: smallest network, longest path.
    always_comb begin : ripple_comb
      logic acc;
      acc = 1'b1;
      p_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
        acc    = acc & x_i[i];
        p_o[i] = acc;
      end
    end

  end else begin : g_tree

    // Level 0 is the raw input; each further level doubles the span that
    // every bit already covers. Level LVLS holds full prefixes.
    for (genvar gk = 0; gk <= LVLS; gk++) begin : g_lvl
      logic [WIDTH-1:0] v;

      if (gk == 0) begin : g_base
        assign v = x_i;
      end else begin : g_comb
        localparam int SPAN = 1 << (gk - 1);

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
          // Kogge-Stone pulls from SPAN bits below; Sklansky pulls from the
          // top of the lower half of the enclosing 2*SPAN block.
          localparam bit USE_KS = (ARCH == AU_ARCH_KOGGE_STONE);
          localparam bit ACTIVE = USE_KS ? (gi >= SPAN) : ((gi & SPAN) != 0);
          localparam int SRC_RAW = USE_KS ? (gi - SPAN)
                                          : (((gi >> gk) << gk) + SPAN - 1);
          localparam int SRC = ACTIVE ? SRC_RAW : 0;

          if (ACTIVE) begin : g_and
            assign v[gi] = g_lvl[gk-1].v[gi] & g_lvl[gk-1].v[SRC];
          end else begin : g_pass
            assign v[gi] = g_lvl[gk-1].v[gi];
          end
        end
      end
    end

    assign p_o = g_lvl[LVLS].v;

  end

endmodule

// File: rtl/au_absval_serial.sv
// au_absval_serial: multi-cycle |a| for wide 2's-complement operands.
// The operand is held in a shift register and one CHUNK-bit slice is
// conditionally complemented and incremented per cycle, LSB slice first,
// with the increment carry held in a flop between slices. A most-negative
// operand comes back unchanged with ovf set.
module au_absval_serial
  import au_absval_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int ARCH  = AU_ARCH_SKLANSKY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = au_clog2_min1(NCH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           st_q, st_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;

  // Slice datapath: t = slice with sign mask applied, r = t + carry.
  logic [CHUNK-1:0] slice_s;
  logic [CHUNK-1:0] slice_t;
  logic [CHUNK-1:0] slice_r;
  logic [CHUNK:0]   pfx_in;
  logic [CHUNK:0]   pfx_out;
  logic [WIDTH-1:0] sreg_shift;

  assign slice_s = sreg_q[CHUNK-1:0];
  assign slice_t = slice_s ^ {CHUNK{neg_q}};
  assign pfx_in  = {slice_t, carry_q};
  assign slice_r = slice_t ^ pfx_out[CHUNK-1:0];

  AU_prefix_and #(
    .WIDTH (CHUNK + 1),
    .ARCH  (ARCH)
  ) u_prefix (
    .x_i (pfx_in),
    .p_o (pfx_out)
  );

  // Processed slice enters at the top; after NCH shifts the word is back
  // in its original bit order.
  if (CHUNK == WIDTH) begin : g_single
    assign sreg_shift = slice_r;
  end else begin : g_multi
    assign sreg_shift = {slice_r, sreg_q[WIDTH-1:CHUNK]};
  end

  assign in_ready  = (st_q == ST_IDLE) & ~rst;
  assign out_valid = (st_q == ST_DONE);
  assign z         = sreg_q;
  assign ovf       = ovf_q;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      sreg_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      sreg_q  <= sreg_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: load in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    sreg_d  = sreg_q;
    ovf_d   = ovf_q;

    unique case (st_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sreg_d  = a;
          neg_d   = a[WIDTH-1];
          carry_d = a[WIDTH-1];
          idx_d   = '0;
          st_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        carry_d = pfx_out[CHUNK];
        sreg_d  = sreg_shift;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          st_d  = ST_DONE;
          // Result MSB still set after negation only for the most-negative
          // input, whose magnitude does not fit.
          ovf_d = neg_q & slice_r[CHUNK-1];
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          st_d = ST_IDLE;
        end
      end

      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // A non-negative operand never increments, so no carry can leave the top.
  carry_out_quiet: assert property (
    @(posedge clk) disable iff (rst)
    ((st_q == ST_RUN) && (idx_q == LAST_IDX) && !neg_q) |-> !pfx_out[CHUNK]
  );

endmodule

// File: tb/tb_au_absval_serial.sv
// Bench for au_absval_serial: directed table on the 8/4 configuration,
// hand sequences for backpressure and mid-run reset, and random operands
// on single-slice (8/8) and bit-serial (16/1) configurations.
module tb_au_absval_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit, 4-bit slices, Sklansky
  logic       in_valid, in_ready, out_valid, out_ready, ovf;
  logic [7:0] a, z;
  // 8-bit, one slice, Kogge-Stone
  logic       in_valid_w, in_ready_w, out_valid_w, out_ready_w, ovf_w;
  logic [7:0] a_w, z_w;
  // 16-bit, 1-bit slices, ripple
  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, ovf_s;
  logic [15:0] a_s, z_s;

  au_absval_serial #(.WIDTH(8), .CHUNK(4),
                     .ARCH(au_absval_serial_pkg::AU_ARCH_SKLANSKY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf));

  au_absval_serial #(.WIDTH(8), .CHUNK(8),
                     .ARCH(au_absval_serial_pkg::AU_ARCH_KOGGE_STONE)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .z(z_w), .ovf(ovf_w));

  au_absval_serial #(.WIDTH(16), .CHUNK(1),
                     .ARCH(au_absval_serial_pkg::AU_ARCH_RIPPLE)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .a(a_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .z(z_s), .ovf(ovf_s));

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] z;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full operation on the 8/4 unit; inputs change and outputs are
  // sampled on the falling edge.
  task automatic run_main(input logic [7:0] av, input logic [7:0] ez,
                          input logic eo, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h00;
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " z"}, 32'(z), 32'(ez));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    $display("op %s a=%02h z=%02h ovf=%0d lat=%0d", tag, av, z, ovf, n);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_w(input logic [7:0] av);
    int n;
    logic [7:0] ez;
    ez = av[7] ? (~av + 8'd1) : av;
    n = 0;
    while (!in_ready_w && n < 20) begin @(negedge clk); n++; end
    in_valid_w = 1'b1;
    a_w        = av;
    @(negedge clk);
    in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 40) begin @(negedge clk); n++; end
    check("w latency", 32'(n), 32'd1);
    check("w z", 32'(z_w), 32'(ez));
    check("w ovf", 32'(ovf_w), 32'(av == 8'h80));
    $display("op w a=%02h z=%02h ovf=%0d lat=%0d", av, z_w, ovf_w, n);
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
  endtask

  task automatic run_s(input logic [15:0] av);
    int n;
    logic [15:0] ez;
    ez = av[15] ? (~av + 16'd1) : av;
    n = 0;
    while (!in_ready_s && n < 20) begin @(negedge clk); n++; end
    in_valid_s = 1'b1;
    a_s        = av;
    @(negedge clk);
    in_valid_s = 1'b0;
    n = 0;
    while (!out_valid_s && n < 60) begin @(negedge clk); n++; end
    check("s latency", 32'(n), 32'd16);
    check("s z", 32'(z_s), 32'(ez));
    check("s ovf", 32'(ovf_s), 32'(av == 16'h8000));
    $display("op s a=%04h z=%04h ovf=%0d lat=%0d", av, z_s, ovf_s, n);
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
  endtask

  initial begin
    vec_t vecs [12];
    int   n;
    int   seen;

    vecs[0]  = '{8'hF3, 8'h0D, 1'b0};
    vecs[1]  = '{8'hF0, 8'h10, 1'b0};
    vecs[2]  = '{8'h25, 8'h25, 1'b0};
    vecs[3]  = '{8'h80, 8'h80, 1'b1};
    vecs[4]  = '{8'hFF, 8'h01, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 1'b0};
    vecs[6]  = '{8'h01, 8'h01, 1'b0};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b0};
    vecs[8]  = '{8'h81, 8'h7F, 1'b0};
    vecs[9]  = '{8'hF8, 8'h08, 1'b0};
    vecs[10] = '{8'h88, 8'h78, 1'b0};
    vecs[11] = '{8'hC0, 8'h40, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;   a = '0;   out_ready = 1'b0;
    in_valid_w = 1'b0; a_w = '0; out_ready_w = 1'b0;
    in_valid_s = 1'b0; a_s = '0; out_ready_s = 1'b0;
    repeat (3) @(negedge clk);
    check("in_ready during rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset z", 32'(z), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_main(vecs[i].a, vecs[i].z, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Backpressure: result held, unit busy, new operands ignored
    in_valid = 1'b1;
    a        = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      a        = 8'h11;
      #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold z", 32'(z), 32'h80);
      check("hold ovf", 32'(ovf), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    a        = 8'h00;
    $display("op hold a=80 z=%02h ovf=%0d", z, ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("no ghost accept", 32'(in_ready), 32'd1);
    run_main(8'hF3, 8'h0D, 1'b0, "after hold");

    // Reset while RUN with idx=1
    in_valid = 1'b1;
    a        = 8'hF3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-abort out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("abort in_ready under rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort z", 32'(z), 32'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    $display("op abort a=F3 out_valid pulses=%0d", seen);
    run_main(8'hF3, 8'h0D, 1'b0, "after abort");

    // Single-slice and bit-serial configurations
    run_w(8'h80); run_w(8'hFF); run_w(8'h00); run_w(8'h7F); run_w(8'hF3);
    for (int i = 0; i < 150; i++) run_w(8'($urandom));
    run_s(16'h8000); run_s(16'hFFFF); run_s(16'h0000);
    run_s(16'h7FFF); run_s(16'h8001); run_s(16'hFF00);
    for (int i = 0; i < 150; i++) run_s(16'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
